// File: rtl/exe_stage_muldiv_if.sv
`default_nettype none
// ============================================================
// Interface : exe_stage_muldiv_if
// Operation request, forwarding inputs and result bus of the execute stage.
// Rev       : 1.0
// ============================================================
interface exe_stage_muldiv_if #(
  parameter int WORD_LEN  = 32,
  parameter int SHAMT_LEN = 5
);
  logic                 in_valid;
  logic                 flush;
  logic [3:0]           exe_cmd;
  logic [1:0]           src1_sel;
  logic [1:0]           src2_sel;
  logic [1:0]           store_sel;
  logic [WORD_LEN-1:0]  op1;
  logic [WORD_LEN-1:0]  op2;
  logic [WORD_LEN-1:0]  store_in;
  logic [WORD_LEN-1:0]  alu_result_mem;
  logic [WORD_LEN-1:0]  result_wb;
  logic [SHAMT_LEN-1:0] shamt;
  logic                 shift_var;
  logic [WORD_LEN-1:0]  result;
  logic [WORD_LEN-1:0]  store_value;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output in_valid, flush, exe_cmd, src1_sel, src2_sel, store_sel,
    output op1, op2, store_in, alu_result_mem, result_wb, shamt, shift_var,
    input  result, store_value, out_valid, busy
  );

  modport slave (
    input  in_valid, flush, exe_cmd, src1_sel, src2_sel, store_sel,
    input  op1, op2, store_in, alu_result_mem, result_wb, shamt, shift_var,
    output result, store_value, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/exe_stage_muldiv.sv
`default_nettype none
// ============================================================
// Module : exe_stage_muldiv
// Execute stage: forwarding, single-cycle ALU/shifter, iterative MUL/DIV.
// Rev    : 1.0
// ============================================================
module exe_stage_muldiv #(
  parameter int WORD_LEN  = 32,
  parameter int SHAMT_LEN = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  exe_stage_muldiv_if.slave bus
);
  localparam logic [3:0] c_CMD_ADD = 4'd0;
  localparam logic [3:0] c_CMD_SUB = 4'd1;
  localparam logic [3:0] c_CMD_AND = 4'd2;
  localparam logic [3:0] c_CMD_OR  = 4'd3;
  localparam logic [3:0] c_CMD_XOR = 4'd4;
  localparam logic [3:0] c_CMD_NOR = 4'd5;
  localparam logic [3:0] c_CMD_SLT = 4'd6;
  localparam logic [3:0] c_CMD_SLL = 4'd7;
  localparam logic [3:0] c_CMD_SRL = 4'd8;
  localparam logic [3:0] c_CMD_SRA = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t                r_state, w_next;
  logic [SHAMT_LEN-1:0]  r_cnt;
  logic [WORD_LEN-1:0]   r_opnd, r_acc, r_mq, r_st, r_result, r_store;
  logic                  r_hi, r_valid;
  logic [WORD_LEN-1:0]   w_a, w_b, w_st, w_alu;
  logic [SHAMT_LEN-1:0]  w_sh;
  logic [2*WORD_LEN-1:0] w_step;
  logic                  w_accept, w_is_mul, w_is_div, w_last;

  function automatic logic [WORD_LEN-1:0] f_fwd(input logic [1:0] sel,
      input logic [WORD_LEN-1:0] rv, mem, wb);
    case (sel)
      2'd1:    return mem;
      2'd2:    return wb;
      default: return rv;
    endcase
  endfunction

  // One shift-add step: {acc, mq} holds the partial product, mq also feeds multiplier bits.
  function automatic logic [2*WORD_LEN-1:0] f_mul_step(input logic [WORD_LEN-1:0] acc, mq, mcand);
    logic [WORD_LEN:0] sum;
    sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    return {sum, mq[WORD_LEN-1:1]};
  endfunction

  // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
  function automatic logic [2*WORD_LEN-1:0] f_div_step(input logic [WORD_LEN-1:0] rem, quo, dvsr);
    logic [WORD_LEN:0]   shifted;
    logic [WORD_LEN+1:0] diff;
    shifted = {rem, quo[WORD_LEN-1]};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    if (diff[WORD_LEN+1]) return {shifted[WORD_LEN-1:0], quo[WORD_LEN-2:0], 1'b0};
    return {diff[WORD_LEN-1:0], quo[WORD_LEN-2:0], 1'b1};
  endfunction

  assign w_a      = f_fwd(bus.src1_sel, bus.op1, bus.alu_result_mem, bus.result_wb);
  assign w_b      = f_fwd(bus.src2_sel, bus.op2, bus.alu_result_mem, bus.result_wb);
  assign w_st     = f_fwd(bus.store_sel, bus.store_in, bus.alu_result_mem, bus.result_wb);
  assign w_sh     = bus.shift_var ? w_a[SHAMT_LEN-1:0] : bus.shamt;
  assign w_accept = bus.in_valid & ~bus.flush & (r_state == S_IDLE);
  assign w_is_mul = (bus.exe_cmd == 4'd10) || (bus.exe_cmd == 4'd11);
  assign w_is_div = (bus.exe_cmd == 4'd12) || (bus.exe_cmd == 4'd13);
  assign w_last   = (r_cnt == SHAMT_LEN'(WORD_LEN - 1));
  assign w_step   = (r_state == S_MUL) ? f_mul_step(r_acc, r_mq, r_opnd)
                                       : f_div_step(r_acc, r_mq, r_opnd);

  always_comb begin
    w_alu = '0;
    case (bus.exe_cmd)
      c_CMD_ADD: w_alu = w_a + w_b;
      c_CMD_SUB: w_alu = w_a - w_b;
      c_CMD_AND: w_alu = w_a & w_b;
      c_CMD_OR:  w_alu = w_a | w_b;
      c_CMD_XOR: w_alu = w_a ^ w_b;
      c_CMD_NOR: w_alu = ~(w_a | w_b);
      c_CMD_SLT: w_alu = {{(WORD_LEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      c_CMD_SLL: w_alu = w_b << w_sh;
      c_CMD_SRL: w_alu = w_b >> w_sh;
      c_CMD_SRA: w_alu = $signed(w_b) >>> w_sh;
      default:   w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul)      w_next = S_MUL;
          else if (w_accept && w_is_div) w_next = S_DIV;
        end
        S_MUL, S_DIV: if (w_last) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_st     <= '0;
      r_hi     <= 1'b0;
      r_result <= '0;
      r_store  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_hi  <= bus.exe_cmd[0];
        r_st  <= w_st;
        if (w_is_mul) begin
          r_opnd <= w_a;
          r_mq   <= w_b;
        end else if (w_is_div) begin
          r_opnd <= w_b;
          r_mq   <= w_a;
        end else begin
          r_result <= w_alu;
          r_store  <= w_st;
          r_valid  <= 1'b1;
        end
      end else if (r_state != S_IDLE) begin
        {r_acc, r_mq} <= w_step;
        r_cnt         <= r_cnt + SHAMT_LEN'(1);
        if (w_last) begin
          // Odd commands (MULHU, REMU) take the upper half of the step result.
          r_result <= r_hi ? w_step[2*WORD_LEN-1:WORD_LEN] : w_step[WORD_LEN-1:0];
          r_store  <= r_st;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign bus.result      = r_result;
  assign bus.store_value = r_store;
  assign bus.out_valid   = r_valid;
  assign bus.busy        = (r_state != S_IDLE);
endmodule
`default_nettype wire
